// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the two-wide fetch queue.
package fetch_queue_pkg;

  localparam int FETCH_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-wide show-ahead instruction buffer between fetch and decode.
// Optional perf counters are compiled in when FETCH_QUEUE_PERF_EN is defined.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = FETCH_QUEUE_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [1:0]                in_valid,
  input  logic [ADDR_WIDTH-1:0]     in_addr_0,
  input  logic [ADDR_WIDTH-1:0]     in_addr_1,
  input  logic [DATA_WIDTH-1:0]     in_instr_0,
  input  logic [DATA_WIDTH-1:0]     in_instr_1,
  input  logic                      in_pred_taken_0,
  input  logic                      in_pred_taken_1,
  input  logic [ADDR_WIDTH-1:0]     in_pred_target_0,
  input  logic [ADDR_WIDTH-1:0]     in_pred_target_1,
  output logic                      fetch_stall,
  input  logic                      deq_ready,
  output logic [1:0]                out_valid,
  output logic [ADDR_WIDTH-1:0]     out_addr_0,
  output logic [ADDR_WIDTH-1:0]     out_addr_1,
  output logic [DATA_WIDTH-1:0]     out_instr_0,
  output logic [DATA_WIDTH-1:0]     out_instr_1,
  output logic                      out_pred_taken_0,
  output logic                      out_pred_taken_1,
  output logic [ADDR_WIDTH-1:0]     out_pred_target_0,
  output logic [ADDR_WIDTH-1:0]     out_pred_target_1,
  output logic [$clog2(DEPTH):0]    count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_empty_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        slot0, slot1, head_e0, head_e1;
  logic [PW-1:0] head, tail, head_nxt1, tail_nxt1;
  logic [1:0]    enq_n, deq_n;

  assign slot0 = '{addr: in_addr_0, instr: in_instr_0,
                   pred_taken: in_pred_taken_0, pred_target: in_pred_target_0};
  assign slot1 = '{addr: in_addr_1, instr: in_instr_1,
                   pred_taken: in_pred_taken_1, pred_target: in_pred_target_1};

  // Stall depends on registered occupancy only, so fetch sees no combinational loop.
  assign fetch_stall = (DEPTH_C - count) < CW'(2);

  always_comb begin
    enq_n = 2'd0;
    if (!fetch_stall && !flush) begin
      case (in_valid)
        2'b01:   enq_n = 2'd1;
        2'b11:   enq_n = 2'd2;
        default: enq_n = 2'd0;
      endcase
    end
  end

  assign out_valid = {count >= CW'(2), count >= CW'(1)};
  assign deq_n     = (deq_ready && !flush) ? popcount2(out_valid) : 2'd0;
  assign head_nxt1 = head + PW'(1);
  assign tail_nxt1 = tail + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  // Payload storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) mem[tail] <= slot0;
    if (enq_n == 2'd2) mem[tail_nxt1] <= slot1;
  end

  assign head_e0 = mem[head];
  assign head_e1 = mem[head_nxt1];

  assign out_addr_0        = head_e0.addr;
  assign out_instr_0       = head_e0.instr;
  assign out_pred_taken_0  = head_e0.pred_taken;
  assign out_pred_target_0 = head_e0.pred_target;
  assign out_addr_1        = head_e1.addr;
  assign out_instr_1       = head_e1.instr;
  assign out_pred_taken_1  = head_e1.pred_taken;
  assign out_pred_target_1 = head_e1.pred_target;

`ifdef FETCH_QUEUE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Counters survive flush so they measure whole-run behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (fetch_stall)         perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (out_valid == 2'b00)  perf_empty_cycles <= sat_inc(perf_empty_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected entries, a monitor checks the head.
module tb_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [1:0]    in_valid;
  logic [AW-1:0] in_addr_0, in_addr_1;
  logic [DW-1:0] in_instr_0, in_instr_1;
  logic          in_pred_taken_0, in_pred_taken_1;
  logic [AW-1:0] in_pred_target_0, in_pred_target_1;
  logic          fetch_stall;
  logic          deq_ready;
  logic [1:0]    out_valid;
  logic [AW-1:0] out_addr_0, out_addr_1;
  logic [DW-1:0] out_instr_0, out_instr_1;
  logic          out_pred_taken_0, out_pred_taken_1;
  logic [AW-1:0] out_pred_target_0, out_pred_target_1;
  logic [3:0]    count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]   perf_stall_cycles, perf_empty_cycles;
`endif

  fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_addr_0(in_addr_0), .in_addr_1(in_addr_1),
    .in_instr_0(in_instr_0), .in_instr_1(in_instr_1),
    .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
    .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
    .fetch_stall(fetch_stall), .deq_ready(deq_ready), .out_valid(out_valid),
    .out_addr_0(out_addr_0), .out_addr_1(out_addr_1),
    .out_instr_0(out_instr_0), .out_instr_1(out_instr_1),
    .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
    .count(count)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_empty_cycles(perf_empty_cycles)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  int   mon_n;
  logic [1:0] mon_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] i);
    ent_t e;
    e.addr   = a;
    e.instr  = i;
    e.taken  = a[3];
    e.target = a + 32'h40;
    return e;
  endfunction

  // One clock of stimulus; exp_stall is the hand-computed stall state for this cycle.
  task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] i0,
                       input logic [31:0] a1, input logic [31:0] i1,
                       input logic dr, input logic fl, input logic exp_stall);
    ent_t e0, e1;
    e0 = mk(a0, i0);
    e1 = mk(a1, i1);
    in_valid         = v;
    in_addr_0        = e0.addr;   in_addr_1        = e1.addr;
    in_instr_0       = e0.instr;  in_instr_1       = e1.instr;
    in_pred_taken_0  = e0.taken;  in_pred_taken_1  = e1.taken;
    in_pred_target_0 = e0.target; in_pred_target_1 = e1.target;
    deq_ready        = dr;
    flush            = fl;
    chk("fetch_stall", 32'(fetch_stall), 32'(exp_stall));
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (!exp_stall && v[0]) begin
      exp_q.push_back(e0);
      if (v[1]) exp_q.push_back(e1);
    end
    #1;
    in_valid  = 2'b00;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && mon_en) begin
      mon_n  = exp_q.size();
      mon_ev = (mon_n >= 2) ? 2'b11 : (mon_n >= 1) ? 2'b01 : 2'b00;
      chk("out_valid", 32'(out_valid), 32'(mon_ev));
      if (mon_ev[0] && out_valid[0]) begin
        chk("out_addr_0",        out_addr_0,              exp_q[0].addr);
        chk("out_instr_0",       out_instr_0,             exp_q[0].instr);
        chk("out_pred_taken_0",  32'(out_pred_taken_0),   32'(exp_q[0].taken));
        chk("out_pred_target_0", out_pred_target_0,       exp_q[0].target);
      end
      if (mon_ev[1] && out_valid[1]) begin
        chk("out_addr_1",        out_addr_1,              exp_q[1].addr);
        chk("out_instr_1",       out_instr_1,             exp_q[1].instr);
        chk("out_pred_taken_1",  32'(out_pred_taken_1),   32'(exp_q[1].taken));
        chk("out_pred_target_1", out_pred_target_1,       exp_q[1].target);
      end
      if (deq_ready && !flush) begin
        if (mon_ev[0]) void'(exp_q.pop_front());
        if (mon_ev[1]) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 2'b00; deq_ready = 1'b0;
    in_addr_0 = '0; in_addr_1 = '0; in_instr_0 = '0; in_instr_1 = '0;
    in_pred_taken_0 = 1'b0; in_pred_taken_1 = 1'b0;
    in_pred_target_0 = '0; in_pred_target_1 = '0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count",     32'(count),       32'd0);
    chk("reset_out_valid", 32'(out_valid),   32'd0);
    chk("reset_stall",     32'(fetch_stall), 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // first two-wide bundle
    cycle(2'b11, 32'h0, 32'h00000013, 32'h4, 32'h00100093, 1'b0, 1'b0, 1'b0);
    chk("t1_count",     32'(count),     32'd2);
    chk("t1_out_valid", 32'(out_valid), 32'd3);
    chk("t1_addr_1",    out_addr_1,     32'h4);
    chk("t1_instr_0",   out_instr_0,    32'h00000013);

    // fill to full; bundles 4..6 are dropped while stalled
    for (int k = 1; k <= 6; k++)
      cycle(2'b11, 32'(8 * k), 32'(32'h1000 + k), 32'(8 * k + 4), 32'(32'h2000 + k),
            1'b0, 1'b0, k >= 4);
    chk("full_count", 32'(count),       32'd8);
    chk("full_stall", 32'(fetch_stall), 32'd1);
    chk("full_head",  out_addr_0,       32'h0);

    // reach count 7, then dequeue two with a stalled bundle
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("drain_count", 32'(count), 32'd6);
    cycle(2'b01, 32'h20, 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("c7_count", 32'(count), 32'd7);
    cycle(2'b11, 32'h28, 32'h3001, 32'h2c, 32'h3002, 1'b1, 1'b0, 1'b1);
    chk("c7_deq_count", 32'(count), 32'd5);

    // flush with a concurrent bundle
    cycle(2'b11, 32'h30, 32'h3003, 32'h34, 32'h3004, 1'b0, 1'b1, 1'b0);
    chk("flush_count",     32'(count),       32'd0);
    chk("flush_out_valid", 32'(out_valid),   32'd0);
    chk("flush_stall",     32'(fetch_stall), 32'd0);

    // single-slot enqueue then pop
    cycle(2'b01, 32'h100, 32'h4000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("single_count",     32'(count),     32'd1);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_addr",      out_addr_0,     32'h100);
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("single_pop_count", 32'(count), 32'd0);
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("empty_deq_count", 32'(count), 32'd0);

    // illegal 2'b10 pattern
    cycle(2'b10, 32'h180, 32'h5000, 32'h184, 32'h5001, 1'b0, 1'b0, 1'b0);
    chk("illegal_count", 32'(count), 32'd0);

    // simultaneous enqueue/dequeue at DEPTH-2, across pointer wrap
    for (int k = 0; k < 3; k++)
      cycle(2'b11, 32'(32'h200 + 16 * k), 32'(32'h6000 + k),
            32'(32'h208 + 16 * k), 32'(32'h6100 + k), 1'b0, 1'b0, 1'b0);
    chk("pre_simul_count", 32'(count), 32'd6);
    cycle(2'b11, 32'h240, 32'h6003, 32'h248, 32'h6103, 1'b1, 1'b0, 1'b0);
    chk("simul_count", 32'(count), 32'd6);
    for (int k = 0; k < 3; k++)
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("simul_drain_count", 32'(count), 32'd0);

    // asynchronous reset between edges
    cycle(2'b11, 32'h300, 32'h7000, 32'h304, 32'h7001, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 32'h308, 32'h7002, 32'h30c, 32'h7003, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd4);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid),   32'd0);
    chk("async_rst_count",     32'(count),       32'd0);
    chk("async_rst_stall",     32'(fetch_stall), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;

    cycle(2'b11, 32'h400, 32'h8000, 32'h404, 32'h8001, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd2);
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_drain", 32'(count), 32'd0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-wide instruction buffer that receives the fetch bundle and feeds decode. Each entry holds one instruction with its address and branch prediction. The queue absorbs decode backpressure and stalls the PC when fewer than two entries are free. It is emptied on a pipeline redirect.

## Interface
Parameters:
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, instruction width
- DEPTH, 8, entry count; power of two, minimum 4

Ports:
- clk  in  1  single clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  redirect; synchronous clear of all entries
- in_valid  in  2  bit0 = slot0 valid, bit1 = slot1 valid; 2'b10 is illegal and ignored
- in_addr_0 / in_addr_1  in  ADDR_WIDTH  slot addresses
- in_instr_0 / in_instr_1  in  DATA_WIDTH  slot instructions
- in_pred_taken_0 / in_pred_taken_1  in  1  BTB taken prediction per slot
- in_pred_target_0 / in_pred_target_1  in  ADDR_WIDTH  BTB target per slot
- fetch_stall  out  1  high when free entries < 2; fetch must hold the PC
- deq_ready  in  1  decode accepts up to two entries this cycle
- out_valid  out  2  head entries presented; 2'b00, 2'b01 or 2'b11 only
- out_addr_0/1, out_instr_0/1, out_pred_taken_0/1, out_pred_target_0/1  out  widths as inputs  head and head+1 entries
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular array with head and tail pointers, each $clog2(DEPTH) bits and wrapping mod DEPTH. Occupancy is held in a separate count register.
- Enqueue happens only when fetch_stall is low and flush is low:
  - in_valid 2'b01 writes slot0 at tail; tail += 1.
  - in_valid 2'b11 writes slot0 at tail and slot1 at tail+1; tail += 2.
  - in_valid 2'b00 or 2'b10 writes nothing.
- Inputs presented while fetch_stall is high are dropped. Fetch holds the PC, so no instruction is lost.
- Outputs are show-ahead:
  - out_valid[0] = count >= 1.
  - out_valid[1] = count >= 2.
  - Fields are read combinationally from head and head+1.
- Dequeue: when deq_ready is high and flush is low, pop popcount(out_valid) entries and advance head by that amount.
- Each cycle, count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue is legal, including when the queue is full minus two.
- When flush is high, head, tail and count all go to 0 and that cycle's enqueue and dequeue are discarded. Flush overrides everything.
- Empty: out_valid = 0 and deq_ready has no effect.
- Full threshold: fetch_stall = (DEPTH - count) < 2. This is combinational from registered count only, with no path from in_valid or deq_ready.
- Entry payload registers are not reset. Only the pointers and count are reset.

## Timing
- Reset (rst low, asynchronous): head = 0, tail = 0, count = 0.
  - Resulting outputs: out_valid = 0, fetch_stall = 0, count = 0.
  - out_* data outputs are don't-care while out_valid is 0.
- Enqueue-to-output latency is one cycle: an entry written at edge N is visible on out_* after edge N.
- Dequeue takes effect at the clock edge; the next pair appears the following cycle.
- Reset asserted mid-operation clears the queue immediately, without waiting for clk.
- Flush and rst have the same end state; flush is sampled at the edge.

## Configuration
- FETCH_QUEUE_PERF_EN defined: adds two outputs, each width 32:
  - perf_stall_cycles counts cycles with fetch_stall high.
  - perf_empty_cycles counts cycles with out_valid == 0.
  - Both saturate at all-ones.
  - Both reset to 0 on rst only; flush does not clear them.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared typedef_pkg additions:
  - fetch_entry_t struct holding addr, instr, pred_taken and pred_target.
  - FETCH_QUEUE_DEPTH constant, default 8.
- No sub-module: storage and pointer logic sit in one module.
- Optional sub-module fetch_queue_perf for the counters under FETCH_QUEUE_PERF_EN.

## Test plan
- Reset, then one cycle of in_valid=2'b11 with addr 0x0/0x4 and instr 0x00000013/0x00100093. Next cycle: out_valid=2'b11 with matching fields and count=2.
- Six cycles of in_valid=2'b11 with deq_ready=0 (DEPTH=8). fetch_stall rises once count=8. The 4th and later bundles are dropped, count stays 8 and out_addr_0 stays 0x0.
- Queue at count=7, deq_ready=1, in_valid=2'b11. fetch_stall is high, so there is no enqueue; count ends at 5.
- Enqueue 2'b01 (addr 0x100), then hold deq_ready=1. Output shows out_valid=2'b01, the entry pops, and the queue is empty after one edge.
- count=5 with flush=1 and in_valid=2'b11 in the same cycle. Next cycle: count=0, out_valid=0, fetch_stall=0.
- in_valid=2'b10 on an empty queue leaves count=0. rst pulsed low between edges at count=4 immediately gives out_valid=0.
